// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control sequencer for a multi-cycle CPU datapath. It steps one shared ALU,
//   register file and memory port through FETCH / DECODE / EXECUTE / MEMORY /
//   WRITEBACK. It also decodes the ALU operation, runs the memory ready
//   handshake, traps on illegal instructions or memory timeouts, and counts
//   retired instructions.
//
// Parameters
//   TIMEOUT     cycles a memory request may wait for mem_ready (1..255)
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   Op          opcode from the instruction register
//   funct3      instruction funct3
//   funct7      instruction funct7
//   mem_ready   memory accepts/completes the current request this cycle
//   mem_req     memory request valid
//   mem_we      write request (qualified by mem_req)
//   AdrSrc      memory address: 0 = PC, 1 = ALU result register
//   IRWrite     load instruction register
//   PCWrite     load PC with ALU result (PC+4)
//   RegWrite    register file write enable
//   ResultSrc   writeback source: 0 = ALU result, 1 = memory data
//   ALUSrcA     ALU A: 00 = PC, 01 = rs1
//   ALUSrcB     ALU B: 00 = rs2, 01 = constant 4, 10 = immediate
//   ALU_control ALU operation code
//   halted      controller is parked in TRAP
//   trap_cause  00 none, 01 illegal instruction, 10 memory timeout
//   retired     saturating count of retired instructions
module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALU_control,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // The wait counter holds the number of cycles already spent waiting, so
    // the request traps when it has waited TIMEOUT-1 cycles and is still not
    // ready in the current one.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;
    logic [1:0] cause_next;
    logic       retire;
    logic [4:0] dec;  // {legal, alu code}

    // R-type and I-type share the funct3 map; they differ in how strictly
    // funct7 is checked (I-type ignores it except for the shift encodings).
    function automatic logic [4:0] alu_decode(input logic [2:0] f3,
                                              input logic [6:0] f7,
                                              input logic       is_r);
        logic       legal;
        logic [3:0] ctl;
        logic       f7_zero;
        logic       f7_alt;
        f7_zero = (f7 == 7'b0000000);
        f7_alt  = (f7 == 7'b0100000);
        legal   = 1'b1;
        ctl     = ALU_ADD;
        case (f3)
            3'b000: begin
                if (is_r) begin
                    ctl   = f7_alt ? ALU_SUB : ALU_ADD;
                    legal = f7_zero || f7_alt;
                end
            end
            3'b001: begin
                ctl   = ALU_SLL;
                legal = f7_zero;
            end
            3'b010: begin
                ctl   = ALU_SLT;
                legal = !is_r || f7_zero;
            end
            3'b011: begin
                ctl   = ALU_SLTU;
                legal = !is_r || f7_zero;
            end
            3'b100: begin
                ctl   = ALU_XOR;
                legal = !is_r || f7_zero;
            end
            3'b101: begin
                ctl   = f7_alt ? ALU_SRA : ALU_SRL;
                legal = f7_zero || f7_alt;
            end
            3'b110: begin
                ctl   = ALU_OR;
                legal = !is_r || f7_zero;
            end
            3'b111: begin
                ctl   = ALU_AND;
                legal = !is_r || f7_zero;
            end
        endcase
        return {legal, ctl};
    endfunction

    assign dec = alu_decode(funct3, funct7, state == S_EXEC_R);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            trap_cause <= '0;
            retired    <= '0;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_next;
            trap_cause <= cause_next;
            if (retire && (retired != '1)) begin
                retired <= retired + 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        wait_next   = '0;   // clears on entry to a request state and on handshake
        cause_next  = trap_cause;
        retire      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        AdrSrc      = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALU_control = ALU_ADD;
        halted      = 1'b0;

        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end else begin
                    wait_next = wait_cnt + 8'd1;
                end
            end

            S_DECODE: begin
                case (Op)
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_EXEC_R, S_EXEC_I: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = (state == S_EXEC_R) ? 2'b00 : 2'b10;
                ALU_control = dec[3:0];
                if (dec[4]) begin
                    state_next = S_WB_ALU;
                end else begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end

            S_MEM_ADDR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                if (Op == OP_LOAD) begin
                    state_next = S_MEM_RD;
                end else if (Op == OP_STORE) begin
                    state_next = S_MEM_WR;
                end else begin
                    // Op changed under us; treat as an illegal instruction.
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end

            S_MEM_RD, S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = (state == S_MEM_WR);
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    if (state == S_MEM_WR) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB_MEM;
                    end
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end else begin
                    wait_next = wait_cnt + 8'd1;
                end
            end

            S_WB_ALU: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_WB_MEM: begin
                RegWrite   = 1'b1;
                ResultSrc  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_TRAP: begin
                halted = 1'b1;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
